// File: rtl/capture_pkg.sv
// Shared encodings for the capture window controller: FSM states and completion status codes.
// Latency: none (constants only).
// Backpressure: n/a.
package capture_pkg;

  // FSM state encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Completion status reported while done is high
  localparam logic [1:0] ST_TIMEOUT    = 2'd0;
  localparam logic [1:0] ST_LIMIT      = 2'd1;
  localparam logic [1:0] ST_ABORT      = 2'd2;
  localparam logic [1:0] ST_NO_TRIGGER = 2'd3;

endpackage

// File: rtl/window_down_counter.sv
// Loadable down-counter that times the record window; flags when it has reached zero.
// Latency: load/decrement take effect on the next rising edge; zero is decoded from the register.
// Backpressure: none; holds its value whenever enable is low and load is not asserted.
//
// Ports: clock, reset_n (async active-low), load/load_value (load wins over enable),
//        enable (decrement by one), zero (count register equals 0; true out of reset).
module window_down_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 enable,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (enable) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/capture_window_ctrl.sv
// One-shot capture window initiator: arm, open on first trigger, close on timeout/limit/abort, report via done/ack.
// Latency: all outputs are registered or decoded from registered state; state changes one edge after the causing input.
// Backpressure: done/status/event_count are held until ack; arm is ignored outside IDLE.
//
// Ports: clock, reset_n (async active-low); arm, abort, trigger, event_limit (0 = unlimited), ack in;
//        busy (ARMED|CAPTURE), record_en (CAPTURE), done (DONE), status, event_count out.
// Optional build macro: CAPTURE_WINDOW_ARM_TIMEOUT_EN -- ARMED also times out after WINDOW_CYCLES
//        without a trigger and finishes with status NO_TRIGGER.
module capture_window_ctrl
  import capture_pkg::*;
#(
  parameter int CNT_WIDTH     = 32,
  parameter int WINDOW_CYCLES = 40000000,
  parameter int EVW           = 24
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           arm,
  input  logic           abort,
  input  logic           trigger,
  input  logic [EVW-1:0] event_limit,
  input  logic           ack,
  output logic           busy,
  output logic           record_en,
  output logic           done,
  output logic [1:0]     status,
  output logic [EVW-1:0] event_count
);

  localparam logic [CNT_WIDTH-1:0] WIN_LOAD = CNT_WIDTH'(WINDOW_CYCLES - 1);

  logic [1:0]     state_q, state_d;
  logic [1:0]     status_q, status_d;
  logic [EVW-1:0] event_count_q, event_count_d;

  logic cnt_load;
  logic cnt_enable;
  logic cnt_zero;

  // One extra bit so the increment can detect wrap for saturation and compare against the limit
  logic [EVW:0]   count_inc;
  logic [EVW-1:0] count_sat;
  logic           limit_hit;

  assign count_inc = {1'b0, event_count_q} + 1'b1;
  assign count_sat = count_inc[EVW] ? event_count_q : count_inc[EVW-1:0];

  // The limit closes the window either on the trigger that reaches it, or on the first CAPTURE
  // cycle when the opening trigger alone already satisfied it (event_limit = 1).
  always_comb begin
    limit_hit = 1'b0;
    if (event_limit != '0) begin
      if (trigger && (count_inc >= {1'b0, event_limit})) begin
        limit_hit = 1'b1;
      end
      if (event_count_q >= event_limit) begin
        limit_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    event_count_d = event_count_q;
    cnt_load      = 1'b0;
    cnt_enable    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d       = S_ARMED;
          event_count_d = '0;
`ifdef CAPTURE_WINDOW_ARM_TIMEOUT_EN
          cnt_load      = 1'b1;
`endif
        end
      end

      S_ARMED: begin
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (trigger) begin
          state_d       = S_CAPTURE;
          cnt_load      = 1'b1;
          event_count_d = EVW'(1);
`ifdef CAPTURE_WINDOW_ARM_TIMEOUT_EN
        end else if (cnt_zero) begin
          state_d  = S_DONE;
          status_d = ST_NO_TRIGGER;
        end else begin
          cnt_enable = 1'b1;
`endif
        end
      end

      S_CAPTURE: begin
        // Stop at zero so the counter parks there after the window closes
        cnt_enable = !cnt_zero;
        // Every trigger in CAPTURE is counted, including one on the closing edge
        if (trigger) begin
          event_count_d = count_sat;
        end
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (limit_hit) begin
          state_d  = S_DONE;
          status_d = ST_LIMIT;
        end else if (cnt_zero) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end
      end

      S_DONE: begin
        if (ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      status_q      <= ST_TIMEOUT;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      event_count_q <= event_count_d;
    end
  end

  window_down_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_window_cnt (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (cnt_load),
    .load_value(WIN_LOAD),
    .enable    (cnt_enable),
    .zero      (cnt_zero)
  );

  assign busy        = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign record_en   = (state_q == S_CAPTURE);
  assign done        = (state_q == S_DONE);
  assign status      = status_q;
  assign event_count = event_count_q;

endmodule
